// File: rtl/md_tap_pkg.sv
// Shared types and constants for the Mega Drive multitap responder.
package md_tap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_TYPES,
    ST_DATA,
    ST_END
  } tapState_e;

  localparam int NUM_PADS  = 4;
  localparam int PAD_W     = 12;
  localparam int ACK_CNT_W = 8;

  // Pad type field encodings on PAD_TYPE
  localparam logic [1:0] PT_BTN3 = 2'b01;
  localparam logic [1:0] PT_BTN6 = 2'b10;

  // Type nibbles reported to the host
  localparam logic [3:0] TYPE_NONE = 4'hF;
  localparam logic [3:0] TYPE_BTN3 = 4'h0;
  localparam logic [3:0] TYPE_BTN6 = 4'h1;

  // Fixed nibbles of the protocol
  localparam logic [3:0] NIB_IDLE     = 4'h3;
  localparam logic [3:0] NIB_END      = 4'hF;
  localparam logic [3:0] NIB_HDR_ZERO = 4'h0;

  // Sequence index landmarks
  localparam logic [4:0] IDX_FIRST_TYPE = 5'd3;
  localparam logic [4:0] IDX_FIRST_DATA = 5'd7;
  localparam logic [4:0] IDX_MAX        = 5'd31;

  // Bit positions inside one 12-bit pad word
  localparam int BIT_UP    = 0;
  localparam int BIT_DOWN  = 1;
  localparam int BIT_LEFT  = 2;
  localparam int BIT_RIGHT = 3;
  localparam int BIT_A     = 4;
  localparam int BIT_B     = 5;
  localparam int BIT_C     = 6;
  localparam int BIT_START = 7;
  localparam int BIT_MODE  = 8;
  localparam int BIT_X     = 9;
  localparam int BIT_Y     = 10;
  localparam int BIT_Z     = 11;

  function automatic logic [3:0] typeCode(input logic [1:0] pt);
    case (pt)
      PT_BTN3: return TYPE_BTN3;
      PT_BTN6: return TYPE_BTN6;
      default: return TYPE_NONE;
    endcase
  endfunction

  // Buttons are active-high on the pads but reported active-low to the host
  function automatic logic [3:0] padNibble(input logic [PAD_W-1:0] pad, input logic [1:0] sel);
    case (sel)
      2'd0:    return ~{pad[BIT_RIGHT], pad[BIT_LEFT], pad[BIT_DOWN], pad[BIT_UP]};
      2'd1:    return ~{pad[BIT_START], pad[BIT_A], pad[BIT_C], pad[BIT_B]};
      default: return ~{pad[BIT_MODE], pad[BIT_X], pad[BIT_Y], pad[BIT_Z]};
    endcase
  endfunction

endpackage

// File: rtl/md_tap_handshake.sv
// TH/TR synchronizers, edge detection, acknowledge delay and idle timeout.
module md_tap_handshake
  import md_tap_pkg::*;
#(
  parameter int ACK_DLY = 8,
  parameter int TIMEOUT = 81200
) (
  input  logic clk,
  input  logic reset,
  input  logic enable_i,
  input  logic th_i,
  input  logic tr_i,
  output logic tr_level_o,
  output logic th_fall,
  output logic th_rise,
  output logic tr_edge,
  output logic ack_fire,
  output logic timeout
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [1:0]           thSync_q, trSync_q;
  logic                 thPrev_q, trPrev_q;
  logic [ACK_CNT_W-1:0] ackCnt_q, ackCnt_d;
  logic [TO_W-1:0]      toCnt_q, toCnt_d;
  logic                 cancel;

  assign tr_level_o = trSync_q[1];
  assign th_fall    = thPrev_q & ~thSync_q[1];
  assign th_rise    = ~thPrev_q & thSync_q[1];
  assign tr_edge    = trPrev_q ^ trSync_q[1];

  // Any TH transition or disabling abandons a pending acknowledge
  assign cancel = th_fall | th_rise | ~enable_i;

  // A one-cycle delay acknowledges in the edge cycle itself; longer delays count down to 1
  assign ack_fire = (ACK_DLY == 1) ? (tr_edge & ~cancel)
                                   : (~cancel & ~tr_edge & (ackCnt_q == ACK_CNT_W'(1)));

  assign timeout = enable_i & ~thSync_q[1] & ~tr_edge & (toCnt_q == TO_W'(TIMEOUT - 1));

  // Ack delay restarts on every TR edge and counts down to zero
  always_comb begin
    ackCnt_d = ackCnt_q;
    if (cancel) begin
      ackCnt_d = '0;
    end else if (tr_edge) begin
      ackCnt_d = ACK_CNT_W'(ACK_DLY - 1);
    end else if (ackCnt_q != '0) begin
      ackCnt_d = ackCnt_q - ACK_CNT_W'(1);
    end
  end

  // Idle timer runs only while TH is low and saturates so it fires once
  always_comb begin
    toCnt_d = toCnt_q;
    if (!enable_i || thSync_q[1] || tr_edge || th_fall) begin
      toCnt_d = '0;
    end else if (toCnt_q != TO_W'(TIMEOUT)) begin
      toCnt_d = toCnt_q + TO_W'(1);
    end
  end

  // Synchronizer, edge history and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      thSync_q <= 2'b11;
      trSync_q <= 2'b11;
      thPrev_q <= 1'b1;
      trPrev_q <= 1'b1;
      ackCnt_q <= '0;
      toCnt_q  <= '0;
    end else begin
      thSync_q <= {thSync_q[0], th_i};
      trSync_q <= {trSync_q[0], tr_i};
      thPrev_q <= thSync_q[1];
      trPrev_q <= trSync_q[1];
      ackCnt_q <= ackCnt_d;
      toCnt_q  <= toCnt_d;
    end
  end

endmodule

// File: rtl/md_multitap.sv
// Four-pad Mega Drive multitap: sequence FSM, pad snapshot and nibble mux.
module md_multitap
  import md_tap_pkg::*;
#(
  parameter int ACK_DLY = 8,
  parameter int TIMEOUT = 81200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ENABLE,
  input  logic [47:0] PAD,
  input  logic [7:0]  PAD_TYPE,
  input  logic [6:0]  port_in,
  input  logic [6:0]  port_dir,
  output logic [6:0]  port_out
);

  tapState_e   state_q, nextState;
  logic [3:0]  nibble_q, nextNib;
  logic        tl_q;
  logic [4:0]  index_q, idxEff;
  logic [47:0] padSnap_q;
  logic [7:0]  typeSnap_q;

  logic        thIn, trIn;
  logic        trLevel, th_fall, th_rise, tr_edge, ack_fire, timeout;
  logic [4:0]  dataIdx, dataPos;
  logic        dataHit;
  logic [3:0]  dataNib;
  logic [1:0]  typeSel;
  logic [6:0]  drv;

  // A pin the device drives cannot be a host input, so it reads as high
  assign thIn = port_dir[6] ? 1'b1 : port_in[6];
  assign trIn = port_dir[5] ? 1'b1 : port_in[5];

  md_tap_handshake #(
    .ACK_DLY (ACK_DLY),
    .TIMEOUT (TIMEOUT)
  ) u_handshake (
    .clk        (clk),
    .reset      (reset),
    .enable_i   (ENABLE),
    .th_i       (thIn),
    .tr_i       (trIn),
    .tr_level_o (trLevel),
    .th_fall    (th_fall),
    .th_rise    (th_rise),
    .tr_edge    (tr_edge),
    .ack_fire   (ack_fire),
    .timeout    (timeout)
  );

  // Pick the nibble for the index the next acknowledge will present
  always_comb begin
    idxEff = index_q;
    if (tr_edge && index_q != IDX_MAX) begin
      idxEff = index_q + 5'd1;
    end
    dataIdx = idxEff - IDX_FIRST_DATA;
    dataPos = '0;
    dataHit = 1'b0;
    dataNib = NIB_END;
    for (int p = 0; p < NUM_PADS; p++) begin
      for (int j = 0; j < 3; j++) begin
        if ((typeSnap_q[2*p +: 2] == PT_BTN6) ||
            ((typeSnap_q[2*p +: 2] == PT_BTN3) && (j < 2))) begin
          if (dataPos == dataIdx) begin
            dataHit = 1'b1;
            dataNib = padNibble(padSnap_q[PAD_W*p +: PAD_W], 2'(j));
          end
          dataPos = dataPos + 5'd1;
        end
      end
    end
    typeSel = 2'(idxEff - IDX_FIRST_TYPE);
    if (idxEff == 5'd0) begin
      nextState = ST_HEADER;
      nextNib   = NIB_END;
    end else if (idxEff < IDX_FIRST_TYPE) begin
      nextState = ST_HEADER;
      nextNib   = NIB_HDR_ZERO;
    end else if (idxEff < IDX_FIRST_DATA) begin
      nextState = ST_TYPES;
      nextNib   = typeCode(typeSnap_q[2*typeSel +: 2]);
    end else if (dataHit) begin
      nextState = ST_DATA;
      nextNib   = dataNib;
    end else begin
      nextState = ST_END;
      nextNib   = NIB_END;
    end
  end

  // Sequence FSM with registered nibble and TL outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      nibble_q   <= NIB_IDLE;
      tl_q       <= 1'b1;
      index_q    <= '0;
      padSnap_q  <= '0;
      typeSnap_q <= '0;
    end else if (!ENABLE) begin
      state_q  <= ST_IDLE;
      nibble_q <= NIB_IDLE;
      tl_q     <= 1'b1;
    end else if (th_fall) begin
      state_q    <= ST_HEADER;
      nibble_q   <= NIB_END;
      tl_q       <= trLevel;
      index_q    <= '0;
      padSnap_q  <= PAD;
      typeSnap_q <= PAD_TYPE;
    end else if (th_rise || timeout) begin
      state_q  <= ST_IDLE;
      nibble_q <= NIB_IDLE;
      tl_q     <= 1'b1;
    end else begin
      if (tr_edge) begin
        index_q <= idxEff;
      end
      if (ack_fire && state_q != ST_IDLE) begin
        state_q  <= nextState;
        nibble_q <= nextNib;
        tl_q     <= trLevel;
      end
    end
  end

  assign drv      = ENABLE ? {2'b11, tl_q, nibble_q} : 7'h7F;
  assign port_out = (~port_dir & port_in) | (port_dir & drv);

endmodule

// File: tb/tb_md_multitap.sv
// Directed self-checking bench for md_multitap.
module tb_md_multitap;

  localparam int ACK_DLY = 5;
  localparam int TIMEOUT = 400;

  localparam logic [47:0] PAD_MIX   = {24'h0, 12'h200, 12'h010};
  localparam logic [7:0]  TYPES_MIX = 8'h09;

  logic        clk;
  logic        reset;
  logic        ENABLE;
  logic [47:0] PAD;
  logic [7:0]  PAD_TYPE;
  logic [6:0]  port_in;
  logic [6:0]  port_dir;
  logic [6:0]  port_out;

  int errors = 0;
  int checks = 0;

  md_multitap #(
    .ACK_DLY (ACK_DLY),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ENABLE   (ENABLE),
    .PAD      (PAD),
    .PAD_TYPE (PAD_TYPE),
    .port_in  (port_in),
    .port_dir (port_dir),
    .port_out (port_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [7:0] types, input logic [47:0] pads);
    @(negedge clk);
    PAD_TYPE = types;
    PAD      = pads;
  endtask

  task automatic thFall();
    @(negedge clk);
    port_in[6] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic thRise();
    @(negedge clk);
    port_in[6] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic toggleTr();
    @(negedge clk);
    port_in[5] = ~port_in[5];
    repeat (ACK_DLY + 3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (port_out !== 7'h73) begin
      errors++;
      $display("[TB] FAIL reset_port_out: got %h expected %h", port_out, 7'h73);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (port_out !== 7'h73) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: got %h expected %h", port_out, 7'h73);
    end
  endtask

  task automatic test_idle_levels();
    @(negedge clk);
    port_dir = 7'h7F;
    #1;
    checks++;
    if (port_out !== 7'h73) begin
      errors++;
      $display("[TB] FAIL idle_all_driven: got %h expected %h", port_out, 7'h73);
    end
    port_in = 7'h15;
    #1;
    checks++;
    if (port_out !== 7'h73) begin
      errors++;
      $display("[TB] FAIL idle_ignores_input: got %h expected %h", port_out, 7'h73);
    end
    port_in  = 7'h65;
    port_dir = 7'h00;
    #1;
    checks++;
    if (port_out !== 7'h65) begin
      errors++;
      $display("[TB] FAIL idle_passthrough: got %h expected %h", port_out, 7'h65);
    end
    port_in  = 7'h60;
    port_dir = 7'h1F;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (port_out !== 7'h73) begin
      errors++;
      $display("[TB] FAIL idle_restored: got %h expected %h", port_out, 7'h73);
    end
  endtask

  task automatic test_sequence_mixed();
    logic [3:0] expSeq [14] = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h1, 4'hF, 4'hF,
                                4'hF, 4'hB, 4'hF, 4'hF, 4'hB, 4'hF, 4'hF};
    applyStimulus(TYPES_MIX, PAD_MIX);
    thFall();
    checks++;
    if (port_out[4:0] !== {port_in[5], expSeq[0]}) begin
      errors++;
      $display("[TB] FAIL seq_header: got %h expected %h", port_out[4:0], {port_in[5], expSeq[0]});
    end
    applyStimulus(8'hAA, {48{1'b1}});
    for (int i = 1; i < 14; i++) begin
      toggleTr();
      checks++;
      if (port_out[4:0] !== {port_in[5], expSeq[i]}) begin
        errors++;
        $display("[TB] FAIL seq_nib[%0d]: got %h expected %h", i, port_out[4:0], {port_in[5], expSeq[i]});
      end
    end
    thRise();
    checks++;
    if (port_out[4:0] !== 5'h13) begin
      errors++;
      $display("[TB] FAIL seq_back_idle: got %h expected %h", port_out[4:0], 5'h13);
    end
  endtask

  task automatic test_ack_timing();
    logic oldTr;
    applyStimulus(TYPES_MIX, PAD_MIX);
    thFall();
    oldTr = port_in[5];
    @(negedge clk);
    port_in[5] = ~port_in[5];
    repeat (ACK_DLY + 1) @(posedge clk);
    #1;
    checks++;
    if (port_out[4:0] !== {oldTr, 4'hF}) begin
      errors++;
      $display("[TB] FAIL ack_before: got %h expected %h", port_out[4:0], {oldTr, 4'hF});
    end
    @(posedge clk);
    #1;
    checks++;
    if (port_out[4:0] !== {port_in[5], 4'h0}) begin
      errors++;
      $display("[TB] FAIL ack_exact: got %h expected %h", port_out[4:0], {port_in[5], 4'h0});
    end
    toggleTr();
    toggleTr();
    toggleTr();
    checks++;
    if (port_out[4:0] !== {port_in[5], 4'h1}) begin
      errors++;
      $display("[TB] FAIL ack_idx4: got %h expected %h", port_out[4:0], {port_in[5], 4'h1});
    end
    oldTr = port_in[5];
    @(negedge clk);
    port_in[5] = ~port_in[5];
    repeat (2) @(negedge clk);
    port_in[5] = ~port_in[5];
    repeat (ACK_DLY) @(posedge clk);
    #1;
    checks++;
    if (port_out[4:0] !== {oldTr, 4'h1}) begin
      errors++;
      $display("[TB] FAIL ack_restart_hold: got %h expected %h", port_out[4:0], {oldTr, 4'h1});
    end
    @(posedge clk);
    #1;
    checks++;
    if (port_out[4:0] !== {oldTr, 4'h1}) begin
      errors++;
      $display("[TB] FAIL ack_restart_hold2: got %h expected %h", port_out[4:0], {oldTr, 4'h1});
    end
    @(posedge clk);
    #1;
    checks++;
    if (port_out[4:0] !== {oldTr, 4'hF}) begin
      errors++;
      $display("[TB] FAIL ack_restart_fire: got %h expected %h", port_out[4:0], {oldTr, 4'hF});
    end
    thRise();
  endtask

  task automatic test_th_rise();
    logic [3:0] expSeq [6] = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h1, 4'hF};
    applyStimulus(TYPES_MIX, PAD_MIX);
    thFall();
    for (int i = 1; i < 6; i++) begin
      toggleTr();
      checks++;
      if (port_out[3:0] !== expSeq[i]) begin
        errors++;
        $display("[TB] FAIL rise_pre[%0d]: got %h expected %h", i, port_out[3:0], expSeq[i]);
      end
    end
    @(negedge clk);
    port_in[6] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (port_out[3:0] !== 4'hF) begin
      errors++;
      $display("[TB] FAIL rise_sync_wait: got %h expected %h", port_out[3:0], 4'hF);
    end
    @(posedge clk);
    #1;
    checks++;
    if (port_out[4:0] !== 5'h13) begin
      errors++;
      $display("[TB] FAIL rise_idle: got %h expected %h", port_out[4:0], 5'h13);
    end
    thFall();
    checks++;
    if (port_out[4:0] !== {port_in[5], 4'hF}) begin
      errors++;
      $display("[TB] FAIL rise_restart: got %h expected %h", port_out[4:0], {port_in[5], 4'hF});
    end
    toggleTr();
    checks++;
    if (port_out[4:0] !== {port_in[5], 4'h0}) begin
      errors++;
      $display("[TB] FAIL rise_restart_idx1: got %h expected %h", port_out[4:0], {port_in[5], 4'h0});
    end
    @(negedge clk);
    port_in[5] = ~port_in[5];
    @(negedge clk);
    port_in[6] = 1'b1;
    repeat (ACK_DLY + 4) @(posedge clk);
    #1;
    checks++;
    if (port_out[4:0] !== 5'h13) begin
      errors++;
      $display("[TB] FAIL rise_cancel_ack: got %h expected %h", port_out[4:0], 5'h13);
    end
  endtask

  task automatic test_timeout();
    applyStimulus(TYPES_MIX, PAD_MIX);
    thFall();
    toggleTr();
    toggleTr();
    checks++;
    if (port_out[3:0] !== 4'h0) begin
      errors++;
      $display("[TB] FAIL timeout_start: got %h expected %h", port_out[3:0], 4'h0);
    end
    repeat (TIMEOUT - ACK_DLY - 3) @(posedge clk);
    #1;
    checks++;
    if (port_out[3:0] !== 4'h0) begin
      errors++;
      $display("[TB] FAIL timeout_early: got %h expected %h", port_out[3:0], 4'h0);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (port_out[4:0] !== 5'h13) begin
      errors++;
      $display("[TB] FAIL timeout_idle: got %h expected %h", port_out[4:0], 5'h13);
    end
    thRise();
  endtask

  task automatic test_all_none();
    logic [3:0] expNib;
    applyStimulus(8'hC3, {48{1'b1}});
    thFall();
    checks++;
    if (port_out[3:0] !== 4'hF) begin
      errors++;
      $display("[TB] FAIL none_header: got %h expected %h", port_out[3:0], 4'hF);
    end
    for (int i = 1; i <= 40; i++) begin
      toggleTr();
      expNib = (i <= 2) ? 4'h0 : 4'hF;
      checks++;
      if (port_out[4:0] !== {port_in[5], expNib}) begin
        errors++;
        $display("[TB] FAIL none_nib[%0d]: got %h expected %h", i, port_out[4:0], {port_in[5], expNib});
      end
    end
    thRise();
  endtask

  task automatic test_tie_break();
    logic [3:0] expSeq [4] = '{4'hF, 4'h0, 4'h0, 4'h1};
    applyStimulus(8'h06, PAD_MIX);
    @(negedge clk);
    port_in[6] = 1'b0;
    port_in[5] = ~port_in[5];
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (port_out[4:0] !== {port_in[5], 4'hF}) begin
      errors++;
      $display("[TB] FAIL tie_header: got %h expected %h", port_out[4:0], {port_in[5], 4'hF});
    end
    repeat (ACK_DLY + 3) @(posedge clk);
    #1;
    checks++;
    if (port_out[3:0] !== 4'hF) begin
      errors++;
      $display("[TB] FAIL tie_no_advance: got %h expected %h", port_out[3:0], 4'hF);
    end
    for (int i = 1; i < 4; i++) begin
      toggleTr();
      checks++;
      if (port_out[3:0] !== expSeq[i]) begin
        errors++;
        $display("[TB] FAIL tie_nib[%0d]: got %h expected %h", i, port_out[3:0], expSeq[i]);
      end
    end
    thRise();
  endtask

  task automatic test_enable();
    applyStimulus(TYPES_MIX, PAD_MIX);
    thFall();
    toggleTr();
    @(negedge clk);
    ENABLE = 1'b0;
    #1;
    checks++;
    if (port_out !== {port_in[6:5], 5'h1F}) begin
      errors++;
      $display("[TB] FAIL enable_off_drv: got %h expected %h", port_out, {port_in[6:5], 5'h1F});
    end
    toggleTr();
    checks++;
    if (port_out !== {port_in[6:5], 5'h1F}) begin
      errors++;
      $display("[TB] FAIL enable_off_tr: got %h expected %h", port_out, {port_in[6:5], 5'h1F});
    end
    @(negedge clk);
    ENABLE = 1'b1;
    #1;
    checks++;
    if (port_out[4:0] !== 5'h13) begin
      errors++;
      $display("[TB] FAIL enable_forced_idle: got %h expected %h", port_out[4:0], 5'h13);
    end
    toggleTr();
    checks++;
    if (port_out[4:0] !== 5'h13) begin
      errors++;
      $display("[TB] FAIL enable_idle_stays: got %h expected %h", port_out[4:0], 5'h13);
    end
    thRise();
  endtask

  task automatic test_reset_mid();
    applyStimulus(TYPES_MIX, PAD_MIX);
    thFall();
    toggleTr();
    @(negedge clk);
    port_in[5] = ~port_in[5];
    @(negedge clk);
    reset      = 1'b1;
    port_in[6] = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (port_out[4:0] !== 5'h13) begin
      errors++;
      $display("[TB] FAIL reset_mid_idle: got %h expected %h", port_out[4:0], 5'h13);
    end
    repeat (ACK_DLY + 5) @(posedge clk);
    #1;
    checks++;
    if (port_out[4:0] !== 5'h13) begin
      errors++;
      $display("[TB] FAIL reset_mid_no_ack: got %h expected %h", port_out[4:0], 5'h13);
    end
  endtask

  initial begin
    reset    = 1'b1;
    ENABLE   = 1'b1;
    PAD      = '0;
    PAD_TYPE = '0;
    port_in  = 7'h60;
    port_dir = 7'h1F;
    test_reset();
    test_idle_levels();
    test_sequence_mixed();
    test_ack_timing();
    test_th_rise();
    test_timeout();
    test_all_none();
    test_tie_break();
    test_enable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
